// File: rtl/slc3_mem_responder.sv
// SLC-3 memory responder: word-addressed on-chip RAM plus one memory-mapped I/O word,
// answering Mem_OE/Mem_WE strobes with configurable read wait states.
module slc3_mem_responder #(
  parameter int unsigned MEM_AW    = 10,
  parameter int unsigned READ_WAIT = 1,
  parameter logic [15:0] IO_ADDR   = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  input  logic [15:0] Switches,
  output logic [15:0] Data_to_CPU,
  output logic        Data_valid,
  output logic [15:0] HEX_out,
  output logic        Err
);

  localparam int unsigned Depth = 2 ** MEM_AW;
  localparam int unsigned CntW  = $clog2(READ_WAIT + 1);

  typedef enum logic [1:0] {StIdle, StRdWait, StRdHold, StWrHold} state_e;

  state_e            state_q, state_d;
  logic [15:0]       addr_q, addr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [15:0]       hex_q, hex_d;
  logic              err_q, err_d;
  logic [15:0]       data_q;

  logic              rd_en, wr_en;
  logic [15:0]       rd_addr;

  logic [15:0]       ram_q [Depth];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    hex_d   = hex_q;
    err_d   = err_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    rd_addr = addr_q;
    unique case (state_q)
      StIdle: begin
        if (Mem_OE && Mem_WE) begin
          err_d = 1'b1;
        end else if (Mem_OE) begin
          addr_d  = ADDR;
          rd_addr = ADDR;
          if (READ_WAIT == 1) begin
            rd_en   = 1'b1;
            state_d = StRdHold;
          end else begin
            cnt_d   = CntW'(READ_WAIT - 1);
            state_d = StRdWait;
          end
        end else if (Mem_WE) begin
          if (ADDR == IO_ADDR) begin
            hex_d = Data_from_CPU;
          end else begin
            wr_en = 1'b1;
          end
          state_d = StWrHold;
        end
      end
      StRdWait: begin
        if (Mem_WE) err_d = 1'b1;
        if (!Mem_OE) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            rd_en   = 1'b1;
            state_d = StRdHold;
          end
        end
      end
      StRdHold: begin
        if (Mem_WE) err_d = 1'b1;
        if (!Mem_OE) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      end
      StWrHold: begin
        if (Mem_OE) err_d = 1'b1;
        if (!Mem_WE) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (rd_en) valid_d = 1'b1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      hex_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      hex_q   <= hex_d;
      err_q   <= err_d;
      // Registered RAM read; the I/O word overrides the RAM alias at the same low bits.
      if (rd_en) data_q <= (rd_addr == IO_ADDR) ? Switches : ram_q[rd_addr[MEM_AW-1:0]];
    end
  end

  // RAM has no reset so committed writes survive a Reset.
  always_ff @(posedge Clk) begin
    if (wr_en) ram_q[ADDR[MEM_AW-1:0]] <= Data_from_CPU;
  end

  assign Data_to_CPU = data_q;
  assign Data_valid  = valid_q;
  assign HEX_out     = hex_q;
  assign Err         = err_q;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Randomized bench for slc3_mem_responder: two instances (READ_WAIT=1 and 3) share stimulus
// and are compared against a transaction-level memory model.
module tb_slc3_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        oe, we;
  logic [15:0] addr, wdata, sw;
  logic [15:0] d1, d3, h1, h3;
  logic        v1, v3, e1, e3;

  always #5 clk = ~clk;

  slc3_mem_responder #(.MEM_AW(10), .READ_WAIT(1), .IO_ADDR(16'hFFFF)) u_rw1 (
    .Clk(clk), .Reset(rst), .Mem_OE(oe), .Mem_WE(we), .ADDR(addr), .Data_from_CPU(wdata),
    .Switches(sw), .Data_to_CPU(d1), .Data_valid(v1), .HEX_out(h1), .Err(e1)
  );

  slc3_mem_responder #(.MEM_AW(10), .READ_WAIT(3), .IO_ADDR(16'hFFFF)) u_rw3 (
    .Clk(clk), .Reset(rst), .Mem_OE(oe), .Mem_WE(we), .ADDR(addr), .Data_from_CPU(wdata),
    .Switches(sw), .Data_to_CPU(d3), .Data_valid(v3), .HEX_out(h3), .Err(e3)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: memory contents, I/O register, sticky error, last read data per instance
  logic [15:0] mem_m [1024];
  logic [15:0] hex_m;
  logic        err_m;
  logic [15:0] dat1_m, dat3_m;

  logic [15:0] pool [8] = '{16'h0005, 16'h0405, 16'h03FF, 16'hFBFF,
                            16'h0000, 16'h0123, 16'h7FFE, 16'hFFFF};

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] b2w(input bit b);
    return b ? 16'd1 : 16'd0;
  endfunction

  task automatic check_side(input string tag);
    check_eq({tag, " hex1"}, h1, hex_m);
    check_eq({tag, " hex3"}, h3, hex_m);
    check_eq({tag, " err1"}, b2w(e1), b2w(err_m));
    check_eq({tag, " err3"}, b2w(e3), b2w(err_m));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Write strobe held len cycles; later cycles scramble bus values, which must be ignored.
  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int len);
    oe = 1'b0; we = 1'b1; addr = a; wdata = d;
    for (int k = 1; k <= len; k++) begin
      if (k > 1) begin
        addr  = 16'($urandom);
        wdata = 16'($urandom);
      end
      next_cycle();
    end
    if (a == 16'hFFFF) hex_m = d;
    else mem_m[a[9:0]] = d;
    we = 1'b0; addr = 16'($urandom);
    @(negedge clk);
    check_side("wr");
    check_eq("wr valid1", b2w(v1), 16'd0);
    check_eq("wr valid3", b2w(v3), 16'd0);
    next_cycle();
  endtask

  // Read strobe held len cycles; in OE cycle k, k-1 edges have seen OE high.
  task automatic do_read(input logic [15:0] a, input int len, input bit poke, input logic [15:0] swv);
    logic [15:0] exp;
    sw  = swv;
    exp = (a == 16'hFFFF) ? swv : mem_m[a[9:0]];
    oe = 1'b1; we = 1'b0; addr = a;
    for (int k = 1; k <= len; k++) begin
      if (k > 1) addr = 16'($urandom);
      we = poke && (k == 2);
      @(negedge clk);
      check_eq("rd valid1", b2w(v1), b2w(k - 1 >= 1));
      check_eq("rd valid3", b2w(v3), b2w(k - 1 >= 3));
      check_eq("rd data1", d1, (k - 1 >= 1) ? exp : dat1_m);
      check_eq("rd data3", d3, (k - 1 >= 3) ? exp : dat3_m);
      next_cycle();
    end
    if (poke && len >= 2) err_m = 1'b1;
    if (len >= 1) dat1_m = exp;
    if (len >= 3) dat3_m = exp;
    oe = 1'b0; we = 1'b0;
    @(negedge clk);
    check_eq("rd end valid1", b2w(v1), 16'd1);
    check_eq("rd end valid3", b2w(v3), b2w(len >= 3));
    check_eq("rd end data1", d1, dat1_m);
    check_eq("rd end data3", d3, dat3_m);
    check_side("rd end");
    next_cycle();
    @(negedge clk);
    check_eq("rd idle valid1", b2w(v1), 16'd0);
    check_eq("rd idle valid3", b2w(v3), 16'd0);
    check_eq("rd idle data1", d1, dat1_m);
    check_eq("rd idle data3", d3, dat3_m);
    next_cycle();
  endtask

  // Both strobes together from idle: no access, error flagged.
  task automatic do_both(input int len);
    oe = 1'b1; we = 1'b1;
    for (int k = 1; k <= len; k++) begin
      addr  = pool[$urandom_range(0, 7)];
      wdata = 16'($urandom);
      next_cycle();
    end
    err_m = 1'b1;
    oe = 1'b0; we = 1'b0;
    @(negedge clk);
    check_side("both");
    check_eq("both valid1", b2w(v1), 16'd0);
    check_eq("both data1", d1, dat1_m);
    check_eq("both data3", d3, dat3_m);
    next_cycle();
  endtask

  task automatic random_txn(input bit allow_err);
    int r;
    logic [15:0] a;
    r = $urandom_range(0, 9);
    a = pool[$urandom_range(0, 7)];
    if (r < 4) do_write(a, 16'($urandom), $urandom_range(1, 5));
    else if (r < 8 || !allow_err)
      do_read(a, $urandom_range(1, 5), allow_err && ($urandom_range(0, 3) == 0), 16'($urandom));
    else do_both($urandom_range(1, 3));
  endtask

  initial begin
    rst = 1'b1; oe = 1'b0; we = 1'b0; addr = '0; wdata = '0; sw = '0;
    hex_m = '0; err_m = 1'b0; dat1_m = '0; dat3_m = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("reset data1", d1, 16'h0000);
    check_eq("reset data3", d3, 16'h0000);
    check_eq("reset valid1", b2w(v1), 16'd0);
    check_eq("reset valid3", b2w(v3), 16'd0);
    check_side("reset");
    next_cycle();
    rst = 1'b0;
    next_cycle();

    for (int i = 0; i < 7; i++) do_write(pool[i], 16'($urandom), 1);

    do_write(16'h0005, 16'h1234, 2);
    do_read(16'h0005, 2, 1'b0, 16'h0000);
    do_read(16'hFFFF, 2, 1'b0, 16'hBEEF);
    do_write(16'hFFFF, 16'h00A5, 1);
    do_read(16'h03FF, 4, 1'b0, 16'h0000);
    do_write(16'h0123, 16'h5A5A, 1);
    do_read(16'h0123, 4, 1'b0, 16'h0000);
    do_read(16'h0005, 2, 1'b0, 16'h0000);
    do_read(16'h0405, 3, 1'b0, 16'h0000);

    for (int i = 0; i < 40; i++) random_txn(1'b0);

    do_both(2);
    do_read(16'h0123, 3, 1'b0, 16'h0000);

    // Reset in the middle of a read: RD_HOLD for READ_WAIT=1, RD_WAIT for READ_WAIT=3
    do_write(16'hFFFF, 16'hC3C3, 1);
    do_write(16'h0123, 16'h6B6B, 1);
    sw = 16'h1111; oe = 1'b1; addr = 16'h0123;
    next_cycle();
    next_cycle();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("async rst valid1", b2w(v1), 16'd0);
    check_eq("async rst valid3", b2w(v3), 16'd0);
    check_eq("async rst data1", d1, 16'h0000);
    check_eq("async rst data3", d3, 16'h0000);
    hex_m = '0; err_m = 1'b0; dat1_m = '0; dat3_m = '0;
    check_side("async rst");
    oe = 1'b0;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    do_read(16'h0123, 4, 1'b0, 16'h0000);
    do_read(16'h0005, 3, 1'b0, 16'h0000);

    for (int i = 0; i < 60; i++) random_txn(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
